// File: rtl/infra_reset_sequencer.sv
// Staged reset release for IO then user fabric, with an IDELAYCTRL
// readiness watchdog that re-pulses the IDELAYCTRL reset on timeout.
module infra_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES = 256,
  parameter int unsigned RDY_TIMEOUT     = 65535,
  parameter int unsigned IDLY_RST_CYCLES = 16,
  parameter int unsigned STAGE_GAP       = 32,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       idelay_rdy,
  output logic       idelay_rst_req,
  output logic       periph_rst,
  output logic       user_rst,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [3:0] retry_cnt
);

  localparam int unsigned M1 =
    (RST_HOLD_CYCLES > RDY_TIMEOUT) ? RST_HOLD_CYCLES : RDY_TIMEOUT;
  localparam int unsigned M2 =
    (IDLY_RST_CYCLES > STAGE_GAP) ? IDLY_RST_CYCLES : STAGE_GAP;
  localparam int unsigned MAXP = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(RDY_TIMEOUT - 1);
  localparam logic [CW-1:0] IDLY_LAST = CW'(IDLY_RST_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    HOLD, WAIT_RDY, IDLY_RST, REL_PERIPH, DONE, FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [1:0]    sync_q;
  logic          rdy_s;
  logic          idly_q, idly_d;
  logic          periph_q, periph_d;
  logic          user_q, user_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;

  assign rdy_s = sync_q[1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], idelay_rdy};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    unique case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          state_d = REL_PERIPH;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            state_d = IDLY_RST;
            retry_d = retry_q + 4'd1;
          end else begin
            state_d = FAIL;
          end
        end
      end
      IDLY_RST: begin
        if (cnt_q == IDLY_LAST) state_d = HOLD;
      end
      REL_PERIPH: begin
        if (!rdy_s) state_d = HOLD;
        else if (cnt_q == GAP_LAST) state_d = DONE;
      end
      DONE: begin
        cnt_d = '0;
        if (!rdy_s) state_d = HOLD;
      end
      FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Outputs decoded from the next state so each one is a plain flop
    idly_d   = (state_d == IDLY_RST);
    periph_d = !((state_d == REL_PERIPH) || (state_d == DONE));
    user_d   = (state_d != DONE);
    done_d   = (state_d == DONE);
    fail_d   = (state_d == FAIL);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      retry_q  <= 4'd0;
      idly_q   <= 1'b0;
      periph_q <= 1'b1;
      user_q   <= 1'b1;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      idly_q   <= idly_d;
      periph_q <= periph_d;
      user_q   <= user_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign idelay_rst_req = idly_q;
  assign periph_rst     = periph_q;
  assign user_rst       = user_q;
  assign seq_done       = done_q;
  assign seq_fail       = fail_q;
  assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_infra_reset_sequencer.sv
// Directed bench for infra_reset_sequencer: nominal release, retries,
// exhaustion, loss of ready, timeout/ready collision, mid-run reset.
module tb_infra_reset_sequencer;

  logic       clk;
  logic       sys_rst;
  logic       idelay_rdy;
  logic       idelay_rst_req;
  logic       periph_rst;
  logic       user_rst;
  logic       seq_done;
  logic       seq_fail;
  logic [3:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  infra_reset_sequencer #(
    .RST_HOLD_CYCLES(256),
    .RDY_TIMEOUT    (100),
    .IDLY_RST_CYCLES(16),
    .STAGE_GAP      (32),
    .MAX_RETRIES    (3)
  ) dut (
    .sys_clk       (clk),
    .sys_rst       (sys_rst),
    .idelay_rdy    (idelay_rdy),
    .idelay_rst_req(idelay_rst_req),
    .periph_rst    (periph_rst),
    .user_rst      (user_rst),
    .seq_done      (seq_done),
    .seq_fail      (seq_fail),
    .retry_cnt     (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return idelay_rst_req;
      1: return periph_rst;
      2: return user_rst;
      3: return seq_done;
      default: return seq_fail;
    endcase
  endfunction

  // Edges until the selected output equals val; -1 if the budget runs out
  task automatic wait_for(input int sel, input logic val,
                          input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      @(posedge clk);
      #1;
      if (sig(sel) === val) n = i;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_periph"}, periph_rst, 1);
    chk({tag, "_user"}, user_rst, 1);
    chk({tag, "_req"}, idelay_rst_req, 0);
    chk({tag, "_done"}, seq_done, 0);
    chk({tag, "_fail"}, seq_fail, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
  endtask

  task automatic release_rst(input logic rdy);
    sys_rst = 1'b1;
    idelay_rdy = rdy;
    step(2);
    sys_rst = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int fail_at;
    int viol;
    logic prev;
    logic req_seen;

    // Reset state, checked before any clock edge
    sys_rst = 1'b1;
    idelay_rdy = 1'b1;
    #2;
    chk_reset_vals("rst_init");

    // Nominal: hold 256, one WAIT_RDY cycle, then staged release
    release_rst(1'b1);
    wait_for(1, 1'b0, 400, n);
    chk("nom_periph_edge", n, 257);
    chk("nom_user_held", user_rst, 1);
    wait_for(2, 1'b0, 100, n);
    chk("nom_gap", n, 32);
    chk("nom_done", seq_done, 1);
    chk("nom_retry", retry_cnt, 0);
    chk("nom_periph_low", periph_rst, 0);

    // Loss of ready in DONE, then restore
    idelay_rdy = 1'b0;
    wait_for(1, 1'b1, 10, n);
    chk("lost_latency", n, 3);
    chk("lost_user", user_rst, 1);
    chk("lost_done", seq_done, 0);
    idelay_rdy = 1'b1;
    wait_for(1, 1'b0, 400, n);
    chk("lost_rehold", n, 257);
    wait_for(2, 1'b0, 100, n);
    chk("lost_gap", n, 32);
    chk("lost_done_again", seq_done, 1);

    // Two timeouts, then ready after the second pulse
    release_rst(1'b0);
    wait_for(0, 1'b1, 1000, n);
    chk("rt_pulse1_start", n, 356);
    chk("rt_retry1", retry_cnt, 1);
    chk("rt_pulse1_resets", {periph_rst, user_rst}, 2'b11);
    wait_for(0, 1'b0, 100, n);
    chk("rt_pulse1_width", n, 16);
    wait_for(0, 1'b1, 1000, n);
    chk("rt_pulse2_start", n, 356);
    chk("rt_retry2", retry_cnt, 2);
    wait_for(0, 1'b0, 100, n);
    chk("rt_pulse2_width", n, 16);
    idelay_rdy = 1'b1;
    wait_for(1, 1'b0, 400, n);
    chk("rt_periph_edge", n, 257);
    wait_for(2, 1'b0, 100, n);
    chk("rt_gap", n, 32);
    chk("rt_done", seq_done, 1);
    chk("rt_retry_final", retry_cnt, 2);

    // Exhaustion: ready stuck low
    release_rst(1'b0);
    pulses = 0;
    fail_at = -1;
    prev = 1'b0;
    for (int i = 1; i <= 3000 && fail_at < 0; i++) begin
      step(1);
      if (idelay_rst_req && !prev) pulses++;
      prev = idelay_rst_req;
      if (seq_fail) fail_at = i;
    end
    chk("ex_pulses", pulses, 3);
    chk("ex_fail_edge", fail_at, 1472);
    chk("ex_retry", retry_cnt, 3);
    chk("ex_req_low", idelay_rst_req, 0);
    chk("ex_resets", {periph_rst, user_rst}, 2'b11);
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) idelay_rdy = 1'b1;
      step(1);
      if (!periph_rst || !user_rst || !seq_fail || seq_done ||
          idelay_rst_req || retry_cnt != 4'd3) viol++;
    end
    chk("ex_terminal", viol, 0);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("ex_clear_fail", seq_fail, 0);
    chk("ex_clear_retry", retry_cnt, 0);

    // Ready arrives exactly when the WAIT_RDY timeout would fire
    release_rst(1'b0);
    step(353);
    idelay_rdy = 1'b1;
    req_seen = 1'b0;
    n = -1;
    for (int i = 1; i <= 10 && n < 0; i++) begin
      step(1);
      if (idelay_rst_req) req_seen = 1'b1;
      if (!periph_rst) n = i;
    end
    chk("sim_latency", n, 3);
    chk("sim_no_req", req_seen, 0);
    chk("sim_retry", retry_cnt, 0);
    wait_for(2, 1'b0, 100, n);
    chk("sim_gap", n, 32);

    // Reset in the 8th cycle of an idelay_rst_req pulse
    release_rst(1'b0);
    wait_for(0, 1'b1, 1000, n);
    chk("mid_pulse_start", n, 356);
    step(7);
    chk("mid_pulse_active", idelay_rst_req, 1);
    #3;
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("mid_pulse");

    // Reset during REL_PERIPH
    idelay_rdy = 1'b1;
    step(2);
    sys_rst = 1'b0;
    wait_for(1, 1'b0, 400, n);
    chk("mid_rel_edge", n, 257);
    step(5);
    chk("mid_rel_state", {periph_rst, user_rst}, 2'b01);
    #3;
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("mid_rel");

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
